debouncer_multi: RTL and testbench

- Parametrised N-channel debouncer for keyboard and button inputs.
- Each raw asynchronous input goes through its own synchroniser, then its own stability counter. Output state changes only after the input has held a new level for a configurable number of sample strobes.
- Adds per-channel rise/fall pulses, an any-change strobe, a sample-enable for prescaled sampling and a configurable reset level.
- Sits between the board pins and the game/keyboard control FSMs, replacing fixed two-channel debouncing.

---
 rtl/debouncer_multi.sv | 111 +++++++++++
 tb/tb_debouncer_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// N-channel debouncer: per-channel synchroniser and stability counter, with
// registered debounced level, rise/fall pulses and an any-change strobe.
module debouncer_multi #(
  parameter int CHANNELS     = 2,
  parameter int STABLE_COUNT = 20,
  parameter int SYNC_STAGES  = 2,
  parameter bit INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int                  CNT_W    = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = CNT_W'(0);
  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] din_s;

  // Synchroniser chain; shifts every clock regardless of sample_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= INIT_VEC;
      end
    end else begin
      sync_r[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign din_s = sync_r[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             last_r;
    logic             last_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             dout_r;
    logic             dout_nxt_s;
    logic             rise_r;
    logic             rise_nxt_s;
    logic             fall_r;
    logic             fall_nxt_s;

    // Next state: restart on any change, count while stable, accept once saturated
    always_comb begin
      last_nxt_s = last_r;
      cnt_nxt_s  = cnt_r;
      dout_nxt_s = dout_r;
      rise_nxt_s = 1'b0;
      fall_nxt_s = 1'b0;
      if (sample_en) begin
        if (din_s[g] != last_r) begin
          last_nxt_s = din_s[g];
          cnt_nxt_s  = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          // Counter holds here; re-accepting the current level is harmless
          dout_nxt_s = last_r;
          if (last_r != dout_r) begin
            rise_nxt_s = last_r;
            fall_nxt_s = ~last_r;
          end else begin
            rise_nxt_s = 1'b0;
            fall_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end else begin
        last_nxt_s = last_r;
        cnt_nxt_s  = cnt_r;
        dout_nxt_s = dout_r;
      end
    end

    // Per-channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        last_r <= INIT_LEVEL;
        cnt_r  <= CNT_ZERO;
        dout_r <= INIT_LEVEL;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        last_r <= last_nxt_s;
        cnt_r  <= cnt_nxt_s;
        dout_r <= dout_nxt_s;
        rise_r <= rise_nxt_s;
        fall_r <= fall_nxt_s;
      end
    end

    assign dout[g] = dout_r;
    assign rise[g] = rise_r;
    assign fall[g] = fall_r;
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: two builds (INIT_LEVEL 0 and 1) against a
// sample-window reference model, plus directed latency/glitch/reset checks.
module tb_debouncer_multi;

  localparam int CH   = 4;
  localparam int SC   = 4;
  localparam int SYNC = 2;

  logic          clk;
  logic          rst_n;
  logic          sample_en;
  logic [CH-1:0] din0, din1;
  logic [CH-1:0] dout0, rise0, fall0;
  logic [CH-1:0] dout1, rise1, fall1;
  logic          any0, any1;

  int errors = 0;
  int checks = 0;

  debouncer_multi #(.CHANNELS(CH), .STABLE_COUNT(SC), .SYNC_STAGES(SYNC), .INIT_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din0),
    .dout(dout0), .rise(rise0), .fall(fall0), .any_change(any0)
  );

  debouncer_multi #(.CHANNELS(CH), .STABLE_COUNT(SC), .SYNC_STAGES(SYNC), .INIT_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din1),
    .dout(dout1), .rise(rise1), .fall(fall1), .any_change(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once SC+1 consecutive strobed
  // samples of the synchronised input agree and differ from the output.
  logic [CH-1:0] m_dly  [2][SYNC];
  logic [SC:0]   m_win  [2][CH];
  int            m_n    [2][CH];
  logic [CH-1:0] m_dout [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];

  function automatic logic [CH-1:0] init_of(input int k);
    return (k == 1) ? 4'hF : 4'h0;
  endfunction

  task automatic model_step(input int k, input logic [CH-1:0] dinv);
    logic [CH-1:0] ds;
    if (!rst_n) begin
      for (int s = 0; s < SYNC; s++) m_dly[k][s] = init_of(k);
      for (int c = 0; c < CH; c++) begin
        m_win[k][c] = '0;
        m_n[k][c]   = 0;
      end
      m_dout[k] = init_of(k);
      m_rise[k] = 4'h0;
      m_fall[k] = 4'h0;
    end else begin
      ds = m_dly[k][SYNC-1];
      for (int s = SYNC - 1; s > 0; s--) m_dly[k][s] = m_dly[k][s-1];
      m_dly[k][0] = dinv;
      m_rise[k] = 4'h0;
      m_fall[k] = 4'h0;
      if (sample_en) begin
        for (int c = 0; c < CH; c++) begin
          m_win[k][c] = {m_win[k][c][SC-1:0], ds[c]};
          if (m_n[k][c] < SC + 1) m_n[k][c]++;
          if (m_n[k][c] == SC + 1 && (m_win[k][c] == '0 || m_win[k][c] == '1)
              && ds[c] != m_dout[k][c]) begin
            m_dout[k][c] = ds[c];
            m_rise[k][c] = ds[c];
            m_fall[k][c] = ~ds[c];
          end
        end
      end
    end
  endtask

  // Inputs are only changed at negedge+2, so at each negedge they still hold
  // the values the preceding posedge saw.
  initial forever begin
    @(negedge clk);
    model_step(0, din0);
    model_step(1, din1);
    chk("m_dout0", dout0, m_dout[0]);
    chk("m_rise0", rise0, m_rise[0]);
    chk("m_fall0", fall0, m_fall[0]);
    chk("m_any0",  any0,  |(m_rise[0] | m_fall[0]));
    chk("m_dout1", dout1, m_dout[1]);
    chk("m_rise1", rise1, m_rise[1]);
    chk("m_fall1", fall1, m_fall[1]);
    chk("m_any1",  any1,  |(m_rise[1] | m_fall[1]));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b1;
    din0      = 4'h0;
    din1      = 4'hF;
    cyc(1);

    // Reset held while din toggles
    for (int i = 0; i < 5; i++) begin
      din0 = 4'($urandom);
      cyc(1);
      chk("rst_dout0", dout0, 4'h0);
      chk("rst_any0", any0, 1'b0);
      chk("rst_dout1", dout1, 4'hF);
    end
    din0  = 4'h0;
    rst_n = 1'b1;
    cyc(10);

    // Step latency 2+1+4
    din0 = 4'b0001;
    cyc(6);
    chk("step_pre", dout0, 4'b0000);
    cyc(1);
    chk("step_dout", dout0, 4'b0001);
    chk("step_rise", rise0, 4'b0001);
    chk("step_any", any0, 1'b1);
    cyc(1);
    chk("step_rise_end", rise0, 4'b0000);

    // Short pulse on channel 1 is rejected
    din0 = 4'b0011;
    cyc(3);
    din0 = 4'b0001;
    cyc(12);
    chk("glitch", dout0, 4'b0001);

    // Falling step on channel 0
    din0 = 4'b0000;
    cyc(6);
    chk("fall_pre", dout0, 4'b0001);
    cyc(1);
    chk("fall_pulse", fall0, 4'b0001);
    cyc(1);
    chk("fall_end", fall0, 4'b0000);

    // Prescaled sampling on channel 2
    din0 = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      sample_en = (i % 4 == 0);
      cyc(1);
    end
    sample_en = 1'b1;
    chk("presc_dout", dout0, 4'b0100);
    din0 = 4'b0000;
    cyc(15);

    // All channels step together
    din0 = 4'b1111;
    cyc(7);
    chk("sim_rise", rise0, 4'b1111);
    chk("sim_any", any0, 1'b1);
    cyc(1);
    chk("sim_any_end", any0, 1'b0);

    // Reset mid-count takes effect at once
    din0 = 4'b0000;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("rst_imm_dout0", dout0, 4'h0);
    chk("rst_imm_pulse", rise0 | fall0, 4'h0);
    chk("rst_imm_dout1", dout1, 4'hF);
    cyc(3);

    // INIT_LEVEL=1 build falls after 7 edges with din held low
    din1  = 4'h0;
    rst_n = 1'b1;
    cyc(6);
    chk("init1_pre", dout1, 4'hF);
    cyc(1);
    chk("init1_fall", fall1, 4'hF);
    chk("init1_dout", dout1, 4'h0);

    // Randomised phase alternating noisy and quiet inputs
    for (int i = 0; i < 1500; i++) begin
      logic [CH-1:0] f0, f1;
      int lim;
      lim = (((i / 60) % 2) == 0) ? 5 : 40;
      f0 = 4'h0;
      f1 = 4'h0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, lim - 1) == 0) f0[c] = 1'b1;
        if ($urandom_range(0, lim - 1) == 0) f1[c] = 1'b1;
      end
      din0      = din0 ^ f0;
      din1      = din1 ^ f1;
      sample_en = ($urandom_range(0, 3) != 0);
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      cyc(1);
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
